mod_count_ctrl: RTL and testbench

- Sequencing controller for the lab modulo counter datapath (full-adder incrementer + compare + register bank).
- Latches a programmable modulus and wrap budget, then runs the count under a start/pause/stop FSM.
- Emits a terminal-count pulse on each wrap and reports done when the wrap budget is exhausted.
- Sits between top-level switches/buttons and the count display logic; replaces hard-wired compare resets with a configurable sequence.

---
 rtl/mod_count_ctrl.sv | 128 ++++++++++++
 tb/tb_mod_count_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_count_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_count_ctrl : start/pause/stop sequencer for a programmable modulo counter
// Rev 1.0
// ---------------------------------------------------------------------------
module mod_count_ctrl #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              tick,
  input  logic [WIDTH-1:0]  mod_val,
  input  logic [WRAP_W-1:0] wraps,
  output logic [WIDTH-1:0]  count,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  count_n, mod_r, mod_n;
  logic [WRAP_W-1:0] wrap_n, wraps_r, wraps_n;
  logic [WRAP_W-1:0] wrap_inc;
  logic              tc_n;
  logic              last_wrap;

  assign wrap_inc  = wrap_cnt + 1'b1;
  // A zero budget means free-run, so it never terminates the sequence.
  assign last_wrap = (wraps_r != '0) && (wrap_inc == wraps_r);

  always_comb begin
    state_n = state;
    count_n = count;
    wrap_n  = wrap_cnt;
    tc_n    = 1'b0;
    mod_n   = mod_r;
    wraps_n = wraps_r;

    case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_n = IDLE;
          count_n = '0;
          wrap_n  = '0;
        end else if (start) begin
          state_n = RUN;
          mod_n   = mod_val;
          wraps_n = wraps;
          count_n = '0;
          wrap_n  = '0;
        end
      end

      RUN: begin
        if (stop) begin
          state_n = IDLE;
          count_n = '0;
          wrap_n  = '0;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (tick) begin
          if (count == mod_r) begin
            count_n = '0;
            wrap_n  = wrap_inc;
            tc_n    = 1'b1;
            if (last_wrap) begin
              state_n = DONE;
            end
          end else begin
            count_n = count + 1'b1;
          end
        end
      end

      PAUSE: begin
        // The tick on the release cycle is dropped; counting resumes next cycle.
        if (stop) begin
          state_n = IDLE;
          count_n = '0;
          wrap_n  = '0;
        end else if (!pause) begin
          state_n = RUN;
        end
      end

      default: begin
        state_n = IDLE;
        count_n = '0;
        wrap_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wrap_cnt <= '0;
      tc       <= 1'b0;
      mod_r    <= '0;
      wraps_r  <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      wrap_cnt <= wrap_n;
      tc       <= tc_n;
      mod_r    <= mod_n;
      wraps_r  <= wraps_n;
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mod_count_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mod_count_ctrl : scoreboard bench with a behavioural modulo-counter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mod_count_ctrl;

  localparam int WIDTH  = 3;
  localparam int WRAP_W = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, pause, stop, tick;
  logic [WIDTH-1:0]  mod_val;
  logic [WRAP_W-1:0] wraps;
  logic [WIDTH-1:0]  count;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              tc, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];

  int m_mode, m_count, m_wc, m_mod, m_budget, m_tc;

  mod_count_ctrl #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .tick(tick), .mod_val(mod_val), .wraps(wraps), .count(count),
    .wrap_cnt(wrap_cnt), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the counter advances modulo (modulus+1), wraps count modulo 2^WRAP_W.
  task automatic model_step();
    m_tc = 0;
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_wc = 0; m_mod = 0; m_budget = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (stop) begin
            m_mode = M_IDLE; m_count = 0; m_wc = 0;
          end else if (start) begin
            m_mode = M_RUN; m_mod = int'(mod_val); m_budget = int'(wraps);
            m_count = 0; m_wc = 0;
          end
        end
        M_RUN: begin
          if (stop) begin
            m_mode = M_IDLE; m_count = 0; m_wc = 0;
          end else if (pause) begin
            m_mode = M_PAUSE;
          end else if (tick) begin
            m_count = (m_count + 1) % (m_mod + 1);
            if (m_count == 0) begin
              m_tc = 1;
              m_wc = (m_wc + 1) % (1 << WRAP_W);
              if (m_budget != 0 && m_wc == m_budget) m_mode = M_DONE;
            end
          end
        end
        default: begin
          if (stop) begin
            m_mode = M_IDLE; m_count = 0; m_wc = 0;
          end else if (!pause) begin
            m_mode = M_RUN;
          end
        end
      endcase
    end
  endtask

  function automatic logic [9:0] pack_exp();
    logic b, d;
    b = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    d = (m_mode == M_DONE);
    return {m_count[2:0], m_wc[3:0], m_tc[0], b, d};
  endfunction

  task automatic cyc(input bit st, input bit pa, input bit sp, input bit tk,
                     input int mv, input int wv, input bit rs = 1'b0);
    @(negedge clk);
    reset   = rs;
    start   = st;
    pause   = pa;
    stop    = sp;
    tick    = tk;
    mod_val = WIDTH'(mv);
    wraps   = WRAP_W'(wv);
    model_step();
    exp_q.push_back(pack_exp());
  endtask

  // Monitor: outputs are presented every cycle, compared just after the edge.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({count, wrap_cnt, tc, busy, done} !== e) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t actual cnt=%0d wc=%0d tc=%0b busy=%0b done=%0b required cnt=%0d wc=%0d tc=%0b busy=%0b done=%0b",
                   $time, count, wrap_cnt, tc, busy, done, e[9:7], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; tick = 1'b0;
    mod_val = '0; wraps = '0;
    m_mode = M_IDLE; m_count = 0; m_wc = 0; m_mod = 0; m_budget = 0; m_tc = 0;

    cyc(0, 0, 0, 1, 5, 2, 1);
    cyc(1, 1, 0, 1, 5, 2, 1);

    // Two wraps of modulus 6; mod_val/wraps changes after launch must not matter.
    cyc(1, 0, 0, 1, 5, 2);
    repeat (14) cyc(0, 0, 0, 1, 1, 7);
    cyc(0, 0, 1, 0, 0, 0);

    // Free-run modulus 8 for 40 ticks.
    cyc(1, 0, 0, 1, 7, 0);
    repeat (40) cyc(0, 0, 0, 1, 3, 1);
    cyc(0, 0, 1, 0, 0, 0);

    // Pause at count 3, then run on to count 3 with one wrap done.
    cyc(1, 0, 0, 0, 5, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 1, 0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 1, 0, 0);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", {count, wrap_cnt, tc, busy, done}, 32'd0);
    cyc(0, 0, 0, 1, 5, 0, 1);
    cyc(0, 0, 0, 1, 5, 0, 1);

    // Stop beats start in RUN, then mod_val=0 wraps every tick.
    cyc(1, 0, 0, 1, 5, 0);
    repeat (2) cyc(0, 0, 0, 1, 5, 0);
    cyc(1, 0, 1, 1, 5, 0);
    cyc(0, 0, 0, 1, 5, 0);
    cyc(1, 0, 0, 1, 0, 3);
    repeat (4) cyc(0, 0, 0, 1, 0, 3);

    // Relaunch straight out of DONE.
    cyc(1, 0, 0, 1, 2, 1);
    repeat (4) cyc(0, 0, 0, 1, 2, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit st, pa, sp, tk, rs;
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(st, pa, sp, tk, int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4)), rs);
    end

    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
